// File: rtl/mux_rr_stream.sv
// rtl/mux_rr_stream.sv - N-channel W-bit stream mux with registered output and fixed/round-robin grant
// A single output register stage; grant is combinational from in_valid, mode, sel and the rr pointer.
module mux_rr_stream #(
    parameter int W = 4,
    parameter int N = 8,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_ch,
    output logic           out_valid,
    input  logic           out_ready
);

    logic [W-1:0]  out_data_q, out_data_d;
    logic [SW-1:0] out_ch_q, out_ch_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic          slot_free;
    logic          grant_valid;
    logic [SW-1:0] grant_idx;
    logic [W-1:0]  grant_data;
    logic [SW-1:0] cand;
    logic          xfer;

    always_comb begin
        slot_free   = !out_valid_q || out_ready;
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_data  = '0;
        cand        = '0;

        if (!mode) begin
            if (int'(sel) < N && in_valid[sel]) begin
                grant_valid = 1'b1;
                grant_idx   = sel;
            end
        end else begin
            // Scan from the lowest priority (ptr itself) upward so the last hit is the first after ptr.
            for (int i = N; i >= 1; i--) begin
                cand = SW'((int'(ptr_q) + i) % N);
                if (in_valid[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand;
                end
            end
        end

        for (int k = 0; k < N; k++) begin
            if (grant_idx == SW'(k)) begin
                grant_data = in_data[k*W +: W];
            end
        end

        xfer = grant_valid && slot_free;

        in_ready = '0;
        for (int k = 0; k < N; k++) begin
            in_ready[k] = rst_n && xfer && (grant_idx == SW'(k));
        end

        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;

        if (xfer) begin
            out_data_d  = grant_data;
            out_ch_d    = grant_idx;
            out_valid_d = 1'b1;
            if (mode) begin
                ptr_d = grant_idx;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= SW'(N - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_stream.sv
// tb/tb_mux_rr_stream.sv - scoreboard bench for mux_rr_stream (W=4, N=8)
module tb_mux_rr_stream;

    localparam int W  = 4;
    localparam int N  = 8;
    localparam int SW = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_valid = '0;
    logic [N-1:0]   in_ready;
    logic           mode = 1'b0;
    logic [SW-1:0]  sel = '0;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_ch;
    logic           out_valid;
    logic           out_ready = 1'b0;

    logic [W+SW-1:0] sb[$];
    logic [W+SW-1:0] exp_word;
    int n_checks = 0;
    int n_fail   = 0;

    mux_rr_stream #(.W(W), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Accepted output words are checked against the expected queue in order.
    always @(negedge clk) begin
        #3;
        if (rst_n && out_valid && out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got data=%h ch=%0d, expected no word", out_data, out_ch);
            end else begin
                exp_word = sb.pop_front();
                if ({out_data, out_ch} !== exp_word) begin
                    n_fail++;
                    $display("FAIL sb_word: got data=%h ch=%0d, expected data=%h ch=%0d",
                             out_data, out_ch, exp_word[W+SW-1:SW], exp_word[SW-1:0]);
                end
            end
        end
    end

    task automatic set_data(input logic [W-1:0] base);
        for (int k = 0; k < N; k++) in_data[k*W +: W] = base + W'(k);
    endtask

    task automatic push_exp(input int ch, input logic [W-1:0] base);
        sb.push_back({base + W'(ch), SW'(ch)});
    endtask

    task automatic do_reset;
        @(negedge clk); #1;
        rst_n = 1'b0;
        in_valid = '0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic test_reset;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            in_valid  = N'($urandom);
            out_ready = 1'($urandom);
            mode      = 1'($urandom);
            sel       = SW'($urandom);
            in_data   = $urandom;
            #1;
            n_checks += 4;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
            if (out_data !== '0) begin n_fail++; $display("FAIL rst_out_data: got %h expected 0", out_data); end
            if (out_ch !== '0) begin n_fail++; $display("FAIL rst_out_ch: got %0d expected 0", out_ch); end
            if (in_ready !== '0) begin n_fail++; $display("FAIL rst_in_ready: got %h expected 00", in_ready); end
        end
        @(negedge clk); #1;
        rst_n = 1'b1;
        mode = 1'b1;
        in_valid = 8'hFF;
        out_ready = 1'b1;
        set_data(4'h0);
        for (int k = 0; k < 3; k++) push_exp(k, 4'h0);
        repeat (3) @(negedge clk);
        #1 in_valid = '0;
        repeat (2) @(negedge clk);
        #1;
        n_checks += 2;
        if (sb.size() != 0) begin n_fail++; $display("FAIL rst_release_pending: got %0d expected 0", sb.size()); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_release_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_fixed_select;
        do_reset();
        @(negedge clk); #1;
        mode = 1'b0;
        sel = 3'd3;
        in_valid = 8'h08;
        in_data = '0;
        in_data[3*W +: W] = 4'hA;
        out_ready = 1'b1;
        sb.push_back({4'hA, 3'd3});
        #1;
        n_checks++;
        if (in_ready !== 8'h08) begin n_fail++; $display("FAIL fix_in_ready: got %h expected 08", in_ready); end
        @(negedge clk); #1;
        n_checks += 3;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fix_out_valid: got %b expected 1", out_valid); end
        if (out_data !== 4'hA) begin n_fail++; $display("FAIL fix_out_data: got %h expected a", out_data); end
        if (out_ch !== 3'd3) begin n_fail++; $display("FAIL fix_out_ch: got %0d expected 3", out_ch); end
        sel = 3'd5;
        #1;
        n_checks++;
        if (in_ready !== 8'h00) begin n_fail++; $display("FAIL fix_sel5_ready: got %h expected 00", in_ready); end
        @(negedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fix_sel5_drain: got %b expected 0", out_valid); end
        sel = 3'd3;
        in_valid = 8'h01;
        #1;
        n_checks++;
        if (in_ready !== 8'h00) begin n_fail++; $display("FAIL fix_other_ch: got %h expected 00", in_ready); end
        in_valid = '0;
        @(negedge clk); #1;
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL fix_pending: got %0d expected 0", sb.size()); end
    endtask

    task automatic test_rr_full;
        @(negedge clk); #1;
        mode = 1'b1;
        in_valid = 8'hFF;
        out_ready = 1'b1;
        set_data(4'h3);
        for (int i = 0; i < 10; i++) push_exp(i % N, 4'h3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rr_bubble: cycle %0d got %b expected 1", i, out_valid); end
        end
        in_valid = '0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL rr_pending: got %0d expected 0", sb.size()); end
    endtask

    task automatic test_sparse;
        @(negedge clk); #1;
        mode = 1'b1;
        in_valid = 8'h24;
        out_ready = 1'b1;
        set_data(4'h8);
        push_exp(2, 4'h8); push_exp(5, 4'h8); push_exp(2, 4'h8); push_exp(5, 4'h8);
        push_exp(2, 4'h8); push_exp(2, 4'h8); push_exp(2, 4'h8);
        repeat (4) @(negedge clk);
        #1 in_valid = 8'h04;
        repeat (3) @(negedge clk);
        #1 in_valid = '0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL sparse_pending: got %0d expected 0", sb.size()); end
    endtask

    task automatic test_backpressure;
        @(negedge clk); #1;
        mode = 1'b0;
        sel = 3'd1;
        in_valid = 8'h02;
        out_ready = 1'b1;
        in_data = '0;
        in_data[1*W +: W] = 4'h6;
        sb.push_back({4'h6, 3'd1});
        sb.push_back({4'h9, 3'd1});
        @(negedge clk); #1;
        out_ready = 1'b0;
        in_data[1*W +: W] = 4'h9;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            #1;
            n_checks += 3;
            if (out_data !== 4'h6) begin n_fail++; $display("FAIL bp_hold_data: cycle %0d got %h expected 6", i, out_data); end
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid: cycle %0d got %b expected 1", i, out_valid); end
            if (in_ready !== 8'h00) begin n_fail++; $display("FAIL bp_in_ready: cycle %0d got %h expected 00", i, in_ready); end
        end
        @(negedge clk); #1;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 8'h02) begin n_fail++; $display("FAIL bp_release_ready: got %h expected 02", in_ready); end
        @(negedge clk); #1;
        in_valid = '0;
        #1;
        n_checks++;
        if (out_data !== 4'h9) begin n_fail++; $display("FAIL bp_next_word: got %h expected 9", out_data); end
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL bp_pending: got %0d expected 0", sb.size()); end
    endtask

    task automatic test_reset_mid_stream;
        do_reset();
        @(negedge clk); #1;
        mode = 1'b1;
        in_valid = 8'hFF;
        out_ready = 1'b1;
        set_data(4'h0);
        for (int k = 0; k < 5; k++) push_exp(k, 4'h0);
        repeat (5) @(negedge clk);
        #1;
        out_ready = 1'b0;
        in_valid = '0;
        n_checks++;
        if (out_valid !== 1'b1 || out_ch !== 3'd4) begin
            n_fail++; $display("FAIL mid_pre: got valid=%b ch=%0d expected valid=1 ch=4", out_valid, out_ch);
        end
        rst_n = 1'b0;
        #1;
        n_checks += 3;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_drop: got %b expected 0", out_valid); end
        if (out_data !== '0) begin n_fail++; $display("FAIL mid_data: got %h expected 0", out_data); end
        if (sb.size() != 1) begin n_fail++; $display("FAIL mid_pending: got %0d expected 1", sb.size()); end
        sb.delete();
        @(negedge clk); #1;
        rst_n = 1'b1;
        in_valid = 8'h30;
        out_ready = 1'b1;
        push_exp(4, 4'h0); push_exp(5, 4'h0); push_exp(4, 4'h0);
        repeat (3) @(negedge clk);
        #1 in_valid = '0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL mid_after_pending: got %0d expected 0", sb.size()); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fixed_select();
        test_rr_full();
        test_sparse();
        test_backpressure();
        test_reset_mid_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
